mcu_mem_responder: RTL
======================

// Module: mcu_mem_responder
// PURPOSE
//  Responder end of the cache-to-MCU memory port: accepts mem_do_act requests, acks once per request, commits writes,
//  returns reads as a two-word burst at fixed latency. Fronts an on-chip 32-bit word store in the MCU clock domain.
//  Drives dma_mcu_access to open and close CPU service windows against a DMA slot schedule.
// PARAMETERS
//  AW           10  word-address width of internal store (2**AW words)
//  RD_LAT       4   cycles from ack cycle to first read word on mem_datafrommem
//  SLOT_PERIOD  8   length of access schedule period, cycles (>=2)
//  DMA_SLOTS    2   cycles per period reserved for DMA (< SLOT_PERIOD)
// PORTS
//  MCU_CLK          in   1   memory-side clock
//  RST              in   1   async active-low reset
//  mem_addr         in   26  word address from cache
//  mem_we           in   1   1=write, sampled in accept cycle
//  mem_do_act       in   1   request valid
//  mem_dataintomem  in   32  write data
//  mem_ack          out  1   one-cycle accept pulse
//  mem_datafrommem  out  32  read burst data
//  dma_mcu_access   out  1   1=CPU port may issue requests
//  addr_err         out  1   sticky: request addressed beyond 2**AW words
// BEHAVIOUR
//  Reset (async, RST low): state IDLE, mem_ack=0, mem_datafrommem=0, dma_mcu_access=0, addr_err=0, slot cnt=0.
//    Store contents are not reset. Reset mid-burst abandons the burst; no write is committed after reset asserts.
//  FSM states: IDLE, ACK, WAIT, BURST0, BURST1, REARM.
//  IDLE: mem_do_act & dma_mcu_access -> ACK; latch addr, we, data.
//  ACK: mem_ack=1 for exactly this cycle. If we=1, write commits at this edge and next state is REARM.
//    If we=0, next state is WAIT.
//  WAIT: counts RD_LAT-1 cycles, then BURST0. Edge case: RD_LAT=1 goes ACK->BURST0 directly.
//  BURST0: mem_datafrommem = store[A], where A = latched addr. Exactly cycle ack+RD_LAT.
//  BURST1: mem_datafrommem = store[A ^ 1] (partner word, bit0 inverted). Cycle ack+RD_LAT+1.
//  After BURST1 -> REARM. Outside BURST0/1, mem_datafrommem holds its last value.
//  REARM: wait until mem_do_act sampled low, then IDLE.
//    The initiator holds mem_do_act ~2 cycles past ack, so no request is ever acked twice.
//  Out of range: any of mem_addr[25:AW] set -> addr_err<=1 in ACK.
//    Out-of-range write is dropped; out-of-range read returns 32'h0 for both words. Still acked.
//  Write then read of the same word: read returns new data (write committed in ACK, before any later accept).
//  Slot schedule: free-running counter 0..SLOT_PERIOD-1.
//    dma_mcu_access = (cnt >= DMA_SLOTS), registered.
//    Accept requires dma_mcu_access=1 in the IDLE cycle. Once accepted, ack/burst finish even if the window closes.
//  mem_we is ignored outside IDLE.
// CONFIGURATION
//  MCU_RESP_DMA_SLOT_EN defined: slot schedule as above.
//  Not defined: slot counter removed, dma_mcu_access=1 from the first edge after reset release;
//    SLOT_PERIOD and DMA_SLOTS are unused.
// STRUCTURE
//  Package mcu_resp_pkg: state encoding localparams, MCU_ADDR_W=26, MCU_DATA_W=32.
//  Sub-module mcu_slot_timer (SLOT_PERIOD, DMA_SLOTS -> dma_mcu_access), instantiated only under MCU_RESP_DMA_SLOT_EN.
//  Store: inferred BRAM with one read and one write port.
// TESTING
//  1 Write 0xDEADBEEF to addr 0x10 -> mem_ack one pulse; then read 0x10 ->
//    0xDEADBEEF at ack+4, store[0x11] at ack+5.
//  2 Read addr 0x11 -> first word store[0x11], second store[0x10].
//  3 Hold mem_do_act high 3 cycles after ack -> exactly one ack; next request accepted only after a low cycle.
//  4 Request at addr 0x0400 (AW=10) -> ack, addr_err=1 sticky, read words 0, store unchanged.
//  5 SLOT_EN: request pending at cnt=0 -> ack no earlier than cnt=2 cycle;
//    window closing mid-burst -> burst completes.
//  6 Assert RST in WAIT -> mem_ack and mem_datafrommem 0, FSM IDLE, no burst issued.

Source files
------------

// File: rtl/mcu_resp_pkg.sv
// mcu_resp_pkg: bus widths and FSM state encoding shared by the MCU memory responder
package mcu_resp_pkg;
  localparam int MCU_ADDR_W = 26;
  localparam int MCU_DATA_W = 32;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACK    = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_BURST0 = 3'd3;
  localparam logic [2:0] ST_BURST1 = 3'd4;
  localparam logic [2:0] ST_REARM  = 3'd5;
  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_ACK    = ST_ACK,
    S_WAIT   = ST_WAIT,
    S_BURST0 = ST_BURST0,
    S_BURST1 = ST_BURST1,
    S_REARM  = ST_REARM
  } state_e;
endpackage

// File: rtl/mcu_slot_timer.sv
// mcu_slot_timer: free-running slot counter; opens the CPU window for slots >= DMA_SLOTS
module mcu_slot_timer #(
  parameter int SLOT_PERIOD = 8,
  parameter int DMA_SLOTS   = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic dma_mcu_access_o
);
  localparam int CW = $clog2(SLOT_PERIOD);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = (cnt_q == CW'(SLOT_PERIOD - 1)) ? '0 : cnt_q + 1'b1;
  // access is computed from the next count so the registered flag lines up with cnt_q
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt_q            <= '0;
      dma_mcu_access_o <= 1'b0;
    end else begin
      cnt_q            <= cnt_d;
      dma_mcu_access_o <= cnt_d >= CW'(DMA_SLOTS);
    end
endmodule

// File: rtl/mcu_mem_responder.sv
// mcu_mem_responder: cache-to-MCU memory port responder with single ack and two-word read burst.
// Define MCU_RESP_DMA_SLOT_EN to gate request acceptance with the DMA slot schedule.
module mcu_mem_responder
  import mcu_resp_pkg::*;
#(
  parameter int AW          = 10,
  parameter int RD_LAT      = 4,
  parameter int SLOT_PERIOD = 8,
  parameter int DMA_SLOTS   = 2
) (
  input  logic                  MCU_CLK,
  input  logic                  RST,
  input  logic [MCU_ADDR_W-1:0] mem_addr,
  input  logic                  mem_we,
  input  logic                  mem_do_act,
  input  logic [MCU_DATA_W-1:0] mem_dataintomem,
  output logic                  mem_ack,
  output logic [MCU_DATA_W-1:0] mem_datafrommem,
  output logic                  dma_mcu_access,
  output logic                  addr_err
);
  localparam int CW = $clog2(RD_LAT + 1);
  if (SLOT_PERIOD < 2 || DMA_SLOTS >= SLOT_PERIOD || RD_LAT < 1) begin : g_bad_cfg
    $error("mcu_mem_responder: invalid RD_LAT/SLOT_PERIOD/DMA_SLOTS");
  end
  state_e                  state_q;
  logic [AW-1:0]           addr_q, rd_idx;
  logic                    we_q, oor_q;
  logic [MCU_DATA_W-1:0]   wdata_q, rd_word;
  logic [CW-1:0]           wait_q;
  logic [MCU_DATA_W-1:0]   mem_q [2**AW];
  // single read port: BURST0 fetches the partner word for the following BURST1 cycle
  assign rd_idx  = (state_q == S_BURST0) ? addr_q ^ AW'(1) : addr_q;
  assign rd_word = oor_q ? '0 : mem_q[rd_idx];
  always_ff @(posedge MCU_CLK)
    if (state_q == S_ACK && we_q && !oor_q) mem_q[addr_q] <= wdata_q;
  always_ff @(posedge MCU_CLK or negedge RST)
    if (!RST) begin
      state_q         <= S_IDLE;
      mem_ack         <= 1'b0;
      mem_datafrommem <= '0;
      addr_err        <= 1'b0;
      addr_q          <= '0;
      we_q            <= 1'b0;
      oor_q           <= 1'b0;
      wdata_q         <= '0;
      wait_q          <= '0;
    end else begin
      case (state_q)
        S_IDLE:
          if (mem_do_act && dma_mcu_access) begin
            state_q <= S_ACK;
            mem_ack <= 1'b1;
            addr_q  <= mem_addr[AW-1:0];
            we_q    <= mem_we;
            oor_q   <= |mem_addr[MCU_ADDR_W-1:AW];
            wdata_q <= mem_dataintomem;
          end
        S_ACK: begin
          mem_ack <= 1'b0;
          wait_q  <= CW'(1);
          if (oor_q) addr_err <= 1'b1;
          if (we_q) state_q <= S_REARM;
          else if (RD_LAT == 1) begin
            state_q         <= S_BURST0;
            mem_datafrommem <= rd_word;
          end else state_q <= S_WAIT;
        end
        S_WAIT:
          if (wait_q == CW'(RD_LAT - 1)) begin
            state_q         <= S_BURST0;
            mem_datafrommem <= rd_word;
          end else wait_q <= wait_q + 1'b1;
        S_BURST0: begin
          state_q         <= S_BURST1;
          mem_datafrommem <= rd_word;
        end
        S_BURST1: state_q <= S_REARM;
        S_REARM:  if (!mem_do_act) state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
`ifdef MCU_RESP_DMA_SLOT_EN
  mcu_slot_timer #(
    .SLOT_PERIOD(SLOT_PERIOD),
    .DMA_SLOTS  (DMA_SLOTS)
  ) u_slot (
    .clk_i           (MCU_CLK),
    .rst_ni          (RST),
    .dma_mcu_access_o(dma_mcu_access)
  );
`else
  always_ff @(posedge MCU_CLK or negedge RST)
    if (!RST) dma_mcu_access <= 1'b0;
    else      dma_mcu_access <= 1'b1;
`endif
endmodule
